srl_fifo_16: RTL
================

Name: srl_fifo_16

Overview:
- Synchronous FIFO, 16 entries deep, built on SRL16-style shift-register storage.
- Writes always shift into position 0.
- The read side selects the oldest entry through an address tap equal to occupancy−1, i.e. this block is the reader end of the shift-register delay-line storage.
- Used for short command/data elasticity buffers between DMB VME-side logic and downstream consumers in the same clock domain.

Parameters:
- WIDTH, 16, data word width in bits.
- AFULL_LVL, 12, ALMOST_FULL asserts when COUNT >= AFULL_LVL (legal range 1..16).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- WR_EN  input  1  write request; DIN captured when WR_EN=1 and FULL=0.
- DIN  input  WIDTH  write data.
- RD_EN  input  1  read request; accepted when RD_EN=1 and EMPTY=0.
- DOUT  output  WIDTH  registered read data, valid when VALID=1.
- VALID  output  1  one-cycle pulse, the cycle after an accepted read.
- EMPTY  output  1  COUNT==0.
- FULL  output  1  COUNT==16.
- ALMOST_FULL  output  1  COUNT >= AFULL_LVL.
- COUNT  output  5  occupancy, 0..16.
- OVERFLOW  output  1  one-cycle pulse, the cycle after a write is rejected because FULL=1.
- UNDERFLOW  output  1  one-cycle pulse, the cycle after a read is rejected because EMPTY=1.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST sampled on the rising edge of CLK).
- Reset values:
  - COUNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0.
  - DOUT=0, VALID=0, OVERFLOW=0, UNDERFLOW=0.
  - The storage array is not reset, so it maps to SRL primitives. Its stale contents must never be visible, because COUNT=0 after reset.
  - RST asserted mid-operation discards all entries on that edge. A WR_EN/RD_EN presented in the same cycle as RST is ignored.
- Storage: sr[0..15] of WIDTH bits.
  - Accepted write: sr <= {sr[14:0], DIN}, so the newest entry is always at sr[0].
  - Oldest entry is sr[COUNT-1].
  - Read tap address = COUNT-1, 4 bits. The tap is don't-care when COUNT=0.
- Accepted read: DOUT <= sr[COUNT-1] (value before any same-cycle shift), and VALID <= 1 on that edge. Read latency is 1 cycle from RD_EN to DOUT/VALID.
- VALID=0 in any cycle without an accepted read the previous cycle. DOUT holds its last value when VALID=0.
- COUNT update per edge, with wa = write accepted, ra = read accepted:
  - wa only: COUNT+1.
  - ra only: COUNT−1.
  - both: unchanged.
  - neither: unchanged.
- Simultaneous read+write, COUNT=n (1..16 except FULL case below):
  - Read returns the old sr[n-1].
  - The shift moves the remaining entries so the new oldest sits at sr[n-1], and COUNT stays n.
- Full boundary:
  - COUNT=16 with WR_EN=1 and RD_EN=0: write rejected, OVERFLOW pulses next cycle, contents unchanged.
  - COUNT=16 with WR_EN=1 and RD_EN=1: the read is accepted, but the write is still rejected, because FULL is evaluated on the pre-edge state. COUNT becomes 15 and OVERFLOW pulses.
- Empty boundary:
  - COUNT=0 with RD_EN=1: read rejected, UNDERFLOW pulses, VALID stays 0, DOUT unchanged.
  - COUNT=0 with WR_EN=1 and RD_EN=1: the write is accepted and the read is rejected (no fall-through). COUNT becomes 1 and UNDERFLOW pulses.
- Flags: EMPTY, FULL and ALMOST_FULL are decoded from registered COUNT (combinational from a register, no extra latency), so they reflect the post-edge occupancy.
- COUNT never wraps; it saturates by the rules above. Under no input sequence may COUNT exceed 16 or go below 0.
- Data ordering is strict FIFO. No data may be lost except rejected writes.

Test Plan:
- Reset then idle: after RST=1 for 2 cycles with random WR_EN/RD_EN → COUNT=0, EMPTY=1, FULL=0, DOUT=0, VALID=0, no OVERFLOW/UNDERFLOW pulses.
- Fill and drain: write 0x0001..0x0010 on 16 consecutive cycles → FULL=1, COUNT=16, ALMOST_FULL first high when COUNT=12. Then read 16 consecutive cycles → DOUT = 0x0001..0x0010 in order, VALID high 16 cycles, each one cycle after RD_EN, EMPTY=1 at end.
- Overflow: at COUNT=16, write 0xDEAD → OVERFLOW pulse 1 cycle, COUNT=16. Drain returns 0x0001..0x0010 with 0xDEAD absent.
- Underflow: at COUNT=0, RD_EN=1 → UNDERFLOW pulse, VALID=0. At COUNT=0, WR_EN=RD_EN=1 with DIN=0x0055 → COUNT=1 and UNDERFLOW pulse; the next read returns 0x0055.
- Simultaneous R/W: preload 0x00A0,0x00A1,0x00A2 (COUNT=3). Then 4 cycles of WR_EN=RD_EN=1 with DIN 0x00B0..0x00B3 → DOUT sequence 0x00A0,0x00A1,0x00A2,0x00B0, COUNT=3 throughout. Final drain gives 0x00B1,0x00B2,0x00B3.
- Reset mid-operation: COUNT=9, assert RST together with WR_EN=RD_EN=1 → next cycle COUNT=0, EMPTY=1, VALID=0. A subsequent write of 0x0077 then a read return 0x0077, with no stale data visible.

Source files
------------

// File: rtl/srl_fifo_16.sv
// srl_fifo_16: 16-deep synchronous FIFO on shift-register (SRL16-style) storage.
// Writes shift in at sr[0]; reads tap the oldest entry at sr[COUNT-1].
module srl_fifo_16 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic [4:0]       COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam logic [4:0] AFULL_CNT = 5'(AFULL_LVL);
    localparam logic [4:0] DEPTH_CNT = 5'd16;

    logic [WIDTH-1:0] sr [16];
    logic             wr_acc;
    logic             rd_acc;
    logic [3:0]       tap;

    // Accept decisions use pre-edge flags, so a full FIFO rejects a write even
    // when a read is accepted in the same cycle.
    always_comb begin
        wr_acc = WR_EN && !FULL;
        rd_acc = RD_EN && !EMPTY;
        // COUNT=16 wraps to tap 15; tap is don't-care when COUNT=0.
        tap    = COUNT[3:0] - 4'd1;
    end

    // Flags are decoded straight from the registered occupancy.
    always_comb begin
        EMPTY       = (COUNT == 5'd0);
        FULL        = (COUNT == DEPTH_CNT);
        ALMOST_FULL = (COUNT >= AFULL_CNT);
    end

    // Storage shift chain; deliberately unreset so it can map onto SRL primitives.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RST) begin
            sr[0] <= DIN;
            for (int i = 1; i < 16; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Occupancy counter; simultaneous accepted read and write leave it unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= 5'd0;
        end else if (wr_acc && !rd_acc) begin
            COUNT <= COUNT + 5'd1;
        end else if (rd_acc && !wr_acc) begin
            COUNT <= COUNT - 5'd1;
        end
    end

    // Registered read data and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT      <= '0;
            VALID     <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (rd_acc) begin
                DOUT <= sr[tap];
            end
            VALID     <= rd_acc;
            OVERFLOW  <= WR_EN && FULL;
            UNDERFLOW <= RD_EN && EMPTY;
        end
    end

endmodule
